// File: rtl/wb_conmax_slv_owner.sv
// Slave-side ownership stage: locks one master per WISHBONE cycle, muxes its
// request onto the slave port and routes responses back, with a stb watchdog.
module wb_conmax_slv_owner #(
   parameter int AW     = 32,
   parameter int DW     = 32,
   parameter int TO_CNT = 255
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [2:0]        sel_i,
   output logic              next_o,
   input  logic [7:0]        m_cyc_i,
   input  logic [7:0]        m_stb_i,
   input  logic [7:0]        m_we_i,
   input  logic [8*AW-1:0]   m_adr_i,
   input  logic [8*DW-1:0]   m_dat_i,
   input  logic [DW-1:0]     m_sel_i,
   output logic [7:0]        m_ack_o,
   output logic [7:0]        m_err_o,
   output logic [7:0]        m_rty_o,
   output logic              s_cyc_o,
   output logic              s_stb_o,
   output logic              s_we_o,
   output logic [AW-1:0]     s_adr_o,
   output logic [DW-1:0]     s_dat_o,
   output logic [DW/8-1:0]   s_sel_o,
   input  logic              s_ack_i,
   input  logic              s_err_i,
   input  logic              s_rty_i
);

   localparam int SW   = DW / 8;
   localparam int WD_W = (TO_CNT > 0) ? $clog2(TO_CNT + 1) : 1;
   localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TO_CNT);
   localparam logic [WD_W-1:0] WD_ONE   = WD_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OWN  = 2'd1,
      ST_REL  = 2'd2
   } state_t;

   state_t          state_reg, state_next;
   logic [2:0]      owner_reg, owner_next;
   logic [WD_W-1:0] wd_cnt_reg, wd_cnt_next;

   logic [AW-1:0]   adr_arr [8];
   logic [DW-1:0]   dat_arr [8];
   logic [SW-1:0]   sel_arr [8];

   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_master
         assign adr_arr[gi] = m_adr_i[gi*AW +: AW];
         assign dat_arr[gi] = m_dat_i[gi*DW +: DW];
         assign sel_arr[gi] = m_sel_i[gi*SW +: SW];
      end
   endgenerate

   logic in_own, cyc_own, stb_own, any_resp, live, timeout;

   assign in_own   = (state_reg == ST_OWN);
   assign cyc_own  = m_cyc_i[owner_reg];
   assign stb_own  = m_stb_i[owner_reg];
   assign any_resp = s_ack_i | s_err_i | s_rty_i;
   // A response only counts while the owner still holds both cyc and stb.
   assign live     = in_own & cyc_own & stb_own;
   assign timeout  = (TO_CNT != 0) && in_own && cyc_own && (wd_cnt_reg == WD_LIMIT);

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_reg  <= ST_IDLE;
         owner_reg  <= 3'd0;
         wd_cnt_reg <= '0;
      end else begin
         state_reg  <= state_next;
         owner_reg  <= owner_next;
         wd_cnt_reg <= wd_cnt_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      owner_next  = owner_reg;
      wd_cnt_next = '0;
      next_o      = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (m_cyc_i[sel_i]) begin
               owner_next = sel_i;
               state_next = ST_OWN;
            end
         end
         ST_OWN: begin
            if (!cyc_own) begin
               state_next = ST_REL;
            end else if ((TO_CNT != 0) && (wd_cnt_reg != WD_LIMIT) && stb_own && !any_resp) begin
               wd_cnt_next = wd_cnt_reg + WD_ONE;
            end
         end
         ST_REL: begin
            next_o     = 1'b1;
            state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      m_ack_o = 8'h00;
      m_err_o = 8'h00;
      m_rty_o = 8'h00;
      if (live && s_ack_i)
         m_ack_o[owner_reg] = 1'b1;
      if ((live && s_err_i) || timeout)
         m_err_o[owner_reg] = 1'b1;
      if (live && s_rty_i)
         m_rty_o[owner_reg] = 1'b1;
   end

   // Data-path outputs follow the owner in every state but are forced low in reset.
   assign s_cyc_o = in_own & cyc_own;
   assign s_stb_o = in_own & stb_own;
   assign s_we_o  = rst_i & m_we_i[owner_reg];
   assign s_adr_o = rst_i ? adr_arr[owner_reg] : '0;
   assign s_dat_o = rst_i ? dat_arr[owner_reg] : '0;
   assign s_sel_o = rst_i ? sel_arr[owner_reg] : '0;

endmodule

// File: tb/tb_wb_conmax_slv_owner.sv
// Randomized and directed bench for wb_conmax_slv_owner against a cycle-level
// ownership model kept in plain integers.
module tb_wb_conmax_slv_owner;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = DW / 8;
   localparam int TO = 4;

   logic              clk_i = 1'b0;
   logic              rst_i;
   logic [2:0]        sel_i;
   logic              next_o;
   logic [7:0]        m_cyc_i, m_stb_i, m_we_i;
   logic [8*AW-1:0]   m_adr_i;
   logic [8*DW-1:0]   m_dat_i;
   logic [DW-1:0]     m_sel_i;
   logic [7:0]        m_ack_o, m_err_o, m_rty_o;
   logic              s_cyc_o, s_stb_o, s_we_o;
   logic [AW-1:0]     s_adr_o;
   logic [DW-1:0]     s_dat_o;
   logic [SW-1:0]     s_sel_o;
   logic              s_ack_i, s_err_i, s_rty_i;

   always #5 clk_i = ~clk_i;

   wb_conmax_slv_owner #(.AW(AW), .DW(DW), .TO_CNT(TO)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .sel_i(sel_i), .next_o(next_o),
      .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
      .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
      .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
      .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
      .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
      .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i)
   );

   int checks = 0;
   int errors = 0;
   int npulse = 0;

   // Model: current owner (-1 when free), last granted master (drives the data mux),
   // a pending end-of-cycle pulse, and the length of the current silent-stb run.
   int mdl_owner, mdl_mux, mdl_run;
   bit mdl_rel;

   always @(negedge clk_i) if (rst_i === 1'b1 && next_o === 1'b1) npulse++;

   task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] bit_at(input int o, input bit c);
      logic [7:0] v;
      v = 8'h00;
      if (c) v[o] = 1'b1;
      return v;
   endfunction

   task automatic model_reset();
      mdl_owner = -1;
      mdl_mux   = 0;
      mdl_run   = 0;
      mdl_rel   = 1'b0;
   endtask

   task automatic model_check();
      int o;
      bit g, live, tmo;
      o    = mdl_mux;
      g    = (mdl_owner >= 0);
      live = g && m_cyc_i[o] && m_stb_i[o];
      tmo  = g && m_cyc_i[o] && (mdl_run == TO);
      chk_eq("s_cyc", s_cyc_o, g && m_cyc_i[o]);
      chk_eq("s_stb", s_stb_o, g && m_stb_i[o]);
      chk_eq("s_we",  s_we_o,  m_we_i[o]);
      chk_eq("s_adr", s_adr_o, m_adr_i[o*AW +: AW]);
      chk_eq("s_dat", s_dat_o, m_dat_i[o*DW +: DW]);
      chk_eq("s_sel", s_sel_o, m_sel_i[o*SW +: SW]);
      chk_eq("m_ack", m_ack_o, bit_at(o, live && s_ack_i));
      chk_eq("m_err", m_err_o, bit_at(o, (live && s_err_i) || tmo));
      chk_eq("m_rty", m_rty_o, bit_at(o, live && s_rty_i));
      chk_eq("next",  next_o,  mdl_rel);
   endtask

   task automatic model_advance();
      int o;
      o = mdl_mux;
      if (mdl_owner >= 0) begin
         if (!m_cyc_i[o]) begin
            mdl_owner = -1;
            mdl_rel   = 1'b1;
            mdl_run   = 0;
         end else if (mdl_run == TO) mdl_run = 0;
         else if (m_stb_i[o] && !(s_ack_i || s_err_i || s_rty_i)) mdl_run++;
         else mdl_run = 0;
      end else if (mdl_rel) begin
         mdl_rel = 1'b0;
      end else if (m_cyc_i[sel_i]) begin
         mdl_owner = int'(sel_i);
         mdl_mux   = int'(sel_i);
         mdl_run   = 0;
      end
   endtask

   // One clock: compare at the falling edge, then step the model; returns #1 after the rise.
   task automatic cycle();
      @(negedge clk_i);
      model_check();
      model_advance();
      @(posedge clk_i);
      #1;
   endtask

   task automatic set_m(input int n, input bit cyc, input bit stb, input logic [AW-1:0] adr);
      m_cyc_i[n] = cyc;
      m_stb_i[n] = stb;
      m_adr_i[n*AW +: AW] = adr;
   endtask

   task automatic clear_inputs();
      sel_i = 3'd0; m_cyc_i = 8'h00; m_stb_i = 8'h00; m_we_i = 8'h00;
      m_adr_i = '0; m_dat_i = '0; m_sel_i = '0;
      s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout_guard simulation exceeded time budget");
      $fatal(1);
   end

   initial begin
      int np0;
      rst_i = 1'b0;
      clear_inputs();
      model_reset();
      // Reset: even with every master requesting, nothing is granted or driven.
      m_cyc_i = 8'hFF; m_stb_i = 8'hFF; m_we_i = 8'hFF;
      for (int i = 0; i < 8; i++) m_adr_i[i*AW +: AW] = $urandom() | 32'h1;
      m_dat_i = {8{32'hDEAD_BEEF}}; m_sel_i = '1;
      repeat (2) @(posedge clk_i);
      #1;
      chk_eq("rst_s_cyc", s_cyc_o, 1'b0);
      chk_eq("rst_s_stb", s_stb_o, 1'b0);
      chk_eq("rst_s_we",  s_we_o,  1'b0);
      chk_eq("rst_s_adr", s_adr_o, 32'h0);
      chk_eq("rst_s_dat", s_dat_o, 32'h0);
      chk_eq("rst_next",  next_o,  1'b0);
      chk_eq("rst_m_err", m_err_o, 8'h00);
      clear_inputs();
      @(negedge clk_i); rst_i = 1'b1;
      @(posedge clk_i); #1;

      // Single read by master 3.
      sel_i = 3'd3; set_m(3, 1, 1, 32'h100);
      cycle();
      chk_eq("rd_s_cyc", s_cyc_o, 1'b1);
      chk_eq("rd_s_adr", s_adr_o, 32'h100);
      s_ack_i = 1'b1; #1;
      chk_eq("rd_m_ack", m_ack_o, 8'h08);
      cycle();
      s_ack_i = 1'b0; set_m(3, 0, 0, 32'h100);
      cycle();
      chk_eq("rd_next1", next_o, 1'b1);
      cycle();
      chk_eq("rd_next0", next_o, 1'b0);

      // Ownership lock: master 2 keeps the bus although sel_i moves to 5.
      sel_i = 3'd2; set_m(2, 1, 1, 32'h200); set_m(5, 1, 1, 32'h500);
      cycle();
      sel_i = 3'd5;
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk_eq("lock_adr", s_adr_o, 32'h200);
      end
      s_ack_i = 1'b1; #1;
      chk_eq("lock_ack2", m_ack_o, 8'h04);
      cycle();
      s_ack_i = 1'b0; set_m(2, 0, 0, 32'h200);
      cycle();
      chk_eq("lock_next", next_o, 1'b1);
      cycle();
      cycle();
      s_ack_i = 1'b1; #1;
      chk_eq("lock_ack5", m_ack_o, 8'h20);
      cycle();
      s_ack_i = 1'b0; set_m(5, 0, 0, 32'h500);
      repeat (3) cycle();

      // Back-to-back cycles from master 1.
      np0 = npulse;
      sel_i = 3'd1; set_m(1, 1, 1, 32'h10);
      for (int r = 0; r < 3; r++) begin
         cycle();
         cycle();
         set_m(1, 0, 0, 32'h10);
         cycle();
         set_m(1, 1, 1, 32'h10);
      end
      cycle();
      chk_eq("b2b_pulses", npulse - np0, 3);
      set_m(1, 0, 0, 32'h10);
      repeat (3) cycle();

      // Watchdog: silent slave, error every 5th stb cycle, no release.
      np0 = npulse;
      sel_i = 3'd6; set_m(6, 1, 1, 32'h600);
      cycle();
      for (int i = 1; i <= 12; i++) begin
         chk_eq("to_err", m_err_o, (i % 5 == 0) ? 8'h40 : 8'h00);
         cycle();
      end
      chk_eq("to_no_next", npulse - np0, 0);
      set_m(6, 0, 0, 32'h600);
      repeat (3) cycle();

      // Asynchronous reset in the middle of an owned cycle.
      np0 = npulse;
      sel_i = 3'd4; set_m(4, 1, 1, 32'h400);
      cycle();
      s_ack_i = 1'b1; #1;
      chk_eq("ar_ack_pre", m_ack_o, 8'h10);
      #2 rst_i = 1'b0; #1;
      chk_eq("ar_s_cyc", s_cyc_o, 1'b0);
      chk_eq("ar_m_ack", m_ack_o, 8'h00);
      chk_eq("ar_s_adr", s_adr_o, 32'h0);
      model_reset();
      s_ack_i = 1'b0;
      @(negedge clk_i); rst_i = 1'b1; #1;
      model_check();
      model_advance();
      @(posedge clk_i); #1;
      chk_eq("ar_regrant", s_cyc_o, 1'b1);
      chk_eq("ar_no_next", npulse - np0, 0);
      set_m(4, 0, 0, 32'h400);
      repeat (3) cycle();

      // Stray responses in IDLE and in REL are dropped.
      s_ack_i = 1'b1; #1;
      chk_eq("stray_idle", m_ack_o, 8'h00);
      cycle();
      chk_eq("stray_idle_st", s_cyc_o, 1'b0);
      s_ack_i = 1'b0; sel_i = 3'd0; set_m(0, 1, 1, 32'hA0);
      cycle();
      set_m(0, 0, 0, 32'hA0);
      cycle();
      s_ack_i = 1'b1; #1;
      chk_eq("stray_rel", m_ack_o, 8'h00);
      chk_eq("stray_rel_nx", next_o, 1'b1);
      cycle();
      s_ack_i = 1'b0;
      cycle();

      // Randomized traffic checked cycle by cycle against the model.
      for (int n = 0; n < 3000; n++) begin
         for (int m = 0; m < 8; m++)
            if ($urandom_range(7) == 0) m_cyc_i[m] = ~m_cyc_i[m];
         m_stb_i = 8'($urandom()) | 8'($urandom());
         m_we_i  = 8'($urandom());
         for (int m = 0; m < 8; m++) begin
            m_adr_i[m*AW +: AW] = $urandom();
            m_dat_i[m*DW +: DW] = $urandom();
         end
         m_sel_i = $urandom();
         sel_i   = 3'($urandom_range(7));
         s_ack_i = ($urandom_range(7) == 0);
         s_err_i = ($urandom_range(15) == 0);
         s_rty_i = ($urandom_range(15) == 0);
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
